// File: rtl/id_stage_ctrl_pkg.sv
// ============================================================================
// Module   : id_stage_ctrl_pkg
// Purpose  : Shared types and constants for the decode-stage sequencer:
//            RISC-V base opcodes, class index encoding, NOP word, queue
//            occupancy states and the opcode-to-class decode helper.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package id_stage_ctrl_pkg;

    // Base opcodes recognised by the decode stage
    localparam logic [6:0] C_OP_I   = 7'b0010011;
    localparam logic [6:0] C_OP_LD  = 7'b0000011;
    localparam logic [6:0] C_OP_S   = 7'b0100011;
    localparam logic [6:0] C_OP_B   = 7'b1100011;
    localparam logic [6:0] C_OP_J   = 7'b1101111;
    localparam logic [6:0] C_OP_JR  = 7'b1100111;
    localparam logic [6:0] C_OP_U   = 7'b0110111;
    localparam logic [6:0] C_OP_UPC = 7'b0010111;
    localparam logic [6:0] C_OP_R   = 7'b0110011;

    // addi x0,x0,0 shown on the head while no entry is valid
    localparam logic [31:0] C_NOP = 32'h0000_0013;

    // Opcode class index presented to EX
    typedef enum logic [3:0] {
        CLS_I     = 4'd0,
        CLS_LD    = 4'd1,
        CLS_S     = 4'd2,
        CLS_B     = 4'd3,
        CLS_J     = 4'd4,
        CLS_JR    = 4'd5,
        CLS_U     = 4'd6,
        CLS_UPC   = 4'd7,
        CLS_R     = 4'd8,
        CLS_OTHER = 4'd9
    } id_class_e;

    // Queue occupancy
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } id_state_e;

    // Map a 7-bit opcode onto its class index
    function automatic id_class_e decode_class(input logic [6:0] opcode);
        id_class_e cls;
        case (opcode)
            C_OP_I:   cls = CLS_I;
            C_OP_LD:  cls = CLS_LD;
            C_OP_S:   cls = CLS_S;
            C_OP_B:   cls = CLS_B;
            C_OP_J:   cls = CLS_J;
            C_OP_JR:  cls = CLS_JR;
            C_OP_U:   cls = CLS_U;
            C_OP_UPC: cls = CLS_UPC;
            C_OP_R:   cls = CLS_R;
            default:  cls = CLS_OTHER;
        endcase
        return cls;
    endfunction

endpackage

`default_nettype wire

// File: rtl/id_stage_ctrl_imm_gen.sv
// ============================================================================
// Module   : id_stage_ctrl_imm_gen
// Purpose  : Combinational immediate generator and class decoder. Sits on
//            the head-load mux so the head registers capture a finished
//            immediate and class together with the instruction.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_ctrl_imm_gen
    import id_stage_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output logic [XLEN-1:0] o_imm,
    output id_class_e       o_class
);

    logic [31:0] w_imm32;
    id_class_e   w_class;

    // Decode class and assemble the 32-bit immediate for that format
    always_comb begin
        w_class = decode_class(i_instr[6:0]);
        w_imm32 = 32'h0;
        case (w_class)
            CLS_I, CLS_LD, CLS_JR:
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            CLS_S:
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            CLS_B:
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                           i_instr[30:25], i_instr[11:8], 1'b0};
            CLS_J:
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                           i_instr[20], i_instr[30:21], 1'b0};
            CLS_U, CLS_UPC:
                w_imm32 = {i_instr[31:12], 12'h000};
            default:
                w_imm32 = 32'h0;
        endcase
    end

    assign o_class = w_class;
    // Widen to the datapath with sign extension (no-op at XLEN = 32)
    assign o_imm   = XLEN'($signed(w_imm32));

endmodule

`default_nettype wire

// File: rtl/id_stage_ctrl.sv
// ============================================================================
// Module   : id_stage_ctrl
// Purpose  : Decode-stage sequencer between IF and EX. Two-entry skid queue
//            (head + skid register) with valid/ready on both sides, a
//            registered {pc, instr, imm, class} head bundle and flush.
//            Optional macro ID_ILLEGAL_CHK_EN flags unrecognised opcodes on
//            o_id_illegal; when undefined that output is tied low.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_stage_ctrl
    import id_stage_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_RESET = '0
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_if_valid,
    input  logic [31:0]     i_if_instr,
    input  logic [XLEN-1:0] i_if_pc,
    output logic            o_if_ready,
    input  logic            i_flush,
    output logic            o_id_valid,
    input  logic            i_ex_ready,
    output logic [31:0]     o_id_instr,
    output logic [XLEN-1:0] o_id_pc,
    output logic [XLEN-1:0] o_id_imm,
    output logic [3:0]      o_id_class,
    output logic            o_id_illegal
);

    id_state_e       r_state;
    id_state_e       w_state_next;

    logic [31:0]     r_head_instr;
    logic [XLEN-1:0] r_head_pc;
    logic [XLEN-1:0] r_head_imm;
    id_class_e       r_head_class;

    logic [31:0]     r_skid_instr;
    logic [XLEN-1:0] r_skid_pc;

    logic            w_accept;
    logic            w_pop;
    logic            w_load_head;
    logic            w_load_skid;
    logic            w_clear_head;
    logic [31:0]     w_src_instr;
    logic [XLEN-1:0] w_src_pc;
    logic [XLEN-1:0] w_src_imm;
    id_class_e       w_src_class;

    // Ready depends on occupancy only, so there is no comb path IF <-> EX
    assign o_if_ready = (r_state != ST_TWO);
    assign o_id_valid = (r_state != ST_EMPTY);
    assign w_accept   = i_if_valid & o_if_ready;
    assign w_pop      = o_id_valid & i_ex_ready;

    // The skid entry always becomes head before anything newer does
    assign w_src_instr = (r_state == ST_TWO) ? r_skid_instr : i_if_instr;
    assign w_src_pc    = (r_state == ST_TWO) ? r_skid_pc    : i_if_pc;

    id_stage_ctrl_imm_gen #(
        .XLEN (XLEN)
    ) u_imm_gen (
        .i_instr (w_src_instr),
        .o_imm   (w_src_imm),
        .o_class (w_src_class)
    );

    // Next occupancy and head/skid load strobes; flush overrides everything
    always_comb begin
        w_state_next = r_state;
        w_load_head  = 1'b0;
        w_load_skid  = 1'b0;
        w_clear_head = 1'b0;
        if (i_flush) begin
            w_state_next = ST_EMPTY;
            w_clear_head = 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_next = ST_ONE;
                        w_load_head  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_load_head  = 1'b1;
                    end else if (w_accept) begin
                        w_state_next = ST_TWO;
                        w_load_skid  = 1'b1;
                    end else if (w_pop) begin
                        w_state_next = ST_EMPTY;
                        w_clear_head = 1'b1;
                    end
                end
                ST_TWO: begin
                    if (w_pop) begin
                        w_state_next = ST_ONE;
                        w_load_head  = 1'b1;
                    end
                end
                default: begin
                    w_state_next = ST_EMPTY;
                    w_clear_head = 1'b1;
                end
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Head bundle: idle values when empty, otherwise the decoded entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head_instr <= C_NOP;
            r_head_pc    <= PC_RESET;
            r_head_imm   <= '0;
            r_head_class <= CLS_OTHER;
        end else if (w_clear_head) begin
            r_head_instr <= C_NOP;
            r_head_pc    <= PC_RESET;
            r_head_imm   <= '0;
            r_head_class <= CLS_OTHER;
        end else if (w_load_head) begin
            r_head_instr <= w_src_instr;
            r_head_pc    <= w_src_pc;
            r_head_imm   <= w_src_imm;
            r_head_class <= w_src_class;
        end
    end

    // Skid entry holds the second instruction while EX stalls
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_skid_instr <= C_NOP;
            r_skid_pc    <= PC_RESET;
        end else if (w_load_skid) begin
            r_skid_instr <= i_if_instr;
            r_skid_pc    <= i_if_pc;
        end
    end

    assign o_id_instr = r_head_instr;
    assign o_id_pc    = r_head_pc;
    assign o_id_imm   = r_head_imm;
    assign o_id_class = r_head_class;

`ifdef ID_ILLEGAL_CHK_EN
    logic r_head_illegal;

    // Illegal flag travels with the head entry; its immediate is already 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_head_illegal <= 1'b0;
        end else if (w_clear_head) begin
            r_head_illegal <= 1'b0;
        end else if (w_load_head) begin
            r_head_illegal <= (w_src_class == CLS_OTHER);
        end
    end

    assign o_id_illegal = r_head_illegal;
`else
    assign o_id_illegal = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_stage_ctrl.sv
// ============================================================================
// Module   : tb_id_stage_ctrl
// Purpose  : Directed self-checking bench for id_stage_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_stage_ctrl;

    localparam int C_XLEN = 32;

    logic              clk;
    logic              rst_n;
    logic              if_valid;
    logic [31:0]       if_instr;
    logic [C_XLEN-1:0] if_pc;
    logic              if_ready;
    logic              flush;
    logic              id_valid;
    logic              ex_ready;
    logic [31:0]       id_instr;
    logic [C_XLEN-1:0] id_pc;
    logic [C_XLEN-1:0] id_imm;
    logic [3:0]        id_class;
    logic              id_illegal;

    int checks = 0;
    int errors = 0;

`ifdef ID_ILLEGAL_CHK_EN
    localparam logic C_ILL_EXP = 1'b1;
`else
    localparam logic C_ILL_EXP = 1'b0;
`endif

    id_stage_ctrl #(
        .XLEN     (C_XLEN),
        .PC_RESET (32'h0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_if_valid   (if_valid),
        .i_if_instr   (if_instr),
        .i_if_pc      (if_pc),
        .o_if_ready   (if_ready),
        .i_flush      (flush),
        .o_id_valid   (id_valid),
        .i_ex_ready   (ex_ready),
        .o_id_instr   (id_instr),
        .o_id_pc      (id_pc),
        .o_id_imm     (id_imm),
        .o_id_class   (id_class),
        .o_id_illegal (id_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        if_valid = v;
        if_instr = ins;
        if_pc    = pc;
    endtask

    task automatic check_head(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                              input logic [31:0] imm, input logic [3:0] cls);
        check({tag, ".valid"}, id_valid, 1'b1);
        check({tag, ".instr"}, id_instr, ins);
        check({tag, ".pc"},    id_pc,    pc);
        check({tag, ".imm"},   id_imm,   imm);
        check({tag, ".class"}, id_class, cls);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"},   id_valid,   1'b0);
        check({tag, ".instr"},   id_instr,   32'h0000_0013);
        check({tag, ".pc"},      id_pc,      32'h0);
        check({tag, ".imm"},     id_imm,     32'h0);
        check({tag, ".class"},   id_class,   4'd9);
        check({tag, ".illegal"}, id_illegal, 1'b0);
        check({tag, ".ready"},   if_ready,   1'b1);
    endtask

    // Encodings and hand-computed immediates
    localparam logic [31:0] C_ADDI = 32'hFFF00093;   // imm -1, class I
    localparam logic [31:0] C_LUI  = 32'h12345037;   // imm 1234_5000, class U
    localparam logic [31:0] C_BEQ  = 32'hFE000EE3;   // imm -4, class B
    localparam logic [31:0] C_SW   = 32'hFE112C23;   // imm -8, class S
    localparam logic [31:0] C_JAL  = 32'h008000EF;   // imm +8, class J
    localparam logic [31:0] C_ADD  = 32'h002081B3;   // imm 0, class R

    typedef struct {
        logic [31:0] ins;
        logic [31:0] imm;
        logic [3:0]  cls;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{32'hFFC12083, 32'hFFFF_FFFC, 4'd1};  // lw x1,-4(x2)
        vecs[1] = '{32'h00008067, 32'h0000_0000, 4'd5};  // jalr x0,0(x1)
        vecs[2] = '{32'h00001297, 32'h0000_1000, 4'd7};  // auipc x5,1
        vecs[3] = '{32'h80000513, 32'hFFFF_F800, 4'd0};  // addi x10,x0,-2048

        rst_n    = 1'b0;
        flush    = 1'b0;
        ex_ready = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        step();
        check_idle("post_reset");

        // addi with EX ready: visible one cycle after acceptance, then drains
        ex_ready = 1'b1;
        offer(1'b1, C_ADDI, 32'h100);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check_head("addi", C_ADDI, 32'h100, 32'hFFFF_FFFF, 4'd0);
        step();
        check_idle("addi_drain");

        // lui then beq back to back, accept+pop in ONE replaces head
        offer(1'b1, C_LUI, 32'h200);
        step();
        check_head("lui", C_LUI, 32'h200, 32'h1234_5000, 4'd6);
        offer(1'b1, C_BEQ, 32'h204);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check_head("beq", C_BEQ, 32'h204, 32'hFFFF_FFFC, 4'd3);
        step();
        check("beq_drain.valid", id_valid, 1'b0);

        // Remaining formats, one at a time
        foreach (vecs[i]) begin
            offer(1'b1, vecs[i].ins, 32'h400 + 32'(i * 4));
            step();
            offer(1'b0, 32'h0, 32'h0);
            check_head($sformatf("vec%0d", i), vecs[i].ins, 32'h400 + 32'(i * 4),
                       vecs[i].imm, vecs[i].cls);
            step();
        end

        // Backpressure: three offers with EX stalled
        ex_ready = 1'b0;
        offer(1'b1, C_SW, 32'h300);
        step();
        check("bp_one.ready", if_ready, 1'b1);
        offer(1'b1, C_JAL, 32'h304);
        step();
        check("bp_two.ready", if_ready, 1'b0);
        offer(1'b1, C_ADD, 32'h308);
        step();
        check("bp_hold.ready", if_ready, 1'b0);
        check_head("bp_hold", C_SW, 32'h300, 32'hFFFF_FFF8, 4'd2);
        step();
        check_head("bp_hold2", C_SW, 32'h300, 32'hFFFF_FFF8, 4'd2);
        ex_ready = 1'b1;
        step();
        check_head("bp_jal", C_JAL, 32'h304, 32'h0000_0008, 4'd4);
        check("bp_jal.ready", if_ready, 1'b1);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check_head("bp_add", C_ADD, 32'h308, 32'h0, 4'd8);
        step();
        check("bp_drain.valid", id_valid, 1'b0);

        // Flush in TWO with an instruction offered: everything dropped
        ex_ready = 1'b0;
        offer(1'b1, C_LUI, 32'h500);
        step();
        offer(1'b1, C_BEQ, 32'h504);
        step();
        check("fl_pre.ready", if_ready, 1'b0);
        offer(1'b1, C_ADD, 32'h508);
        flush = 1'b1;
        step();
        flush = 1'b0;
        offer(1'b0, 32'h0, 32'h0);
        check_idle("flush");
        ex_ready = 1'b1;
        step();
        check_idle("flush_after");

        // Unrecognised opcode passes as OTHER with zero immediate
        offer(1'b1, 32'h0000_0000, 32'h600);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check_head("illegal", 32'h0, 32'h600, 32'h0, 4'd9);
        check("illegal.flag", id_illegal, C_ILL_EXP);
        step();
        check("illegal_drain.flag", id_illegal, 1'b0);

        // Asynchronous reset while full
        ex_ready = 1'b0;
        offer(1'b1, C_SW, 32'h700);
        step();
        offer(1'b1, C_JAL, 32'h704);
        step();
        offer(1'b0, 32'h0, 32'h0);
        check("rst_pre.ready", if_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async.valid", id_valid, 1'b0);
        check("rst_async.instr", id_instr, 32'h0000_0013);
        step();
        rst_n = 1'b1;
        step();
        check_idle("rst_release");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
